// File: rtl/bf_alu_mt.sv
// Multi-threaded execute stage for a Brainfuck-style core: cell arithmetic, pointer moves, branches, I/O.
// Optional GETC input port and opcode are built when ALU_GETC_EN is defined.
module bf_alu_mt #(
    parameter  int DATA_W    = 16,
    parameter  int PTR_W     = 16,
    parameter  int NTHREADS  = 4,
    parameter  int PTR_RESET = 128,
    localparam int TID_W     = $clog2(NTHREADS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ins_in,
    input  logic              ins_valid,
    input  logic [TID_W-1:0]  tid_in,
    input  logic [DATA_W-1:0] val_in,
    output logic              stall,
    output logic [DATA_W-1:0] val_out,
    output logic              wb_en,
    output logic [TID_W-1:0]  wb_tid,
    output logic [PTR_W-1:0]  ptr_select,
    output logic [PTR_W-1:0]  ptr_wb,
    output logic [15:0]       branch_val,
    output logic              branch_en,
    output logic [TID_W-1:0]  branch_tid,
    input  logic              fork_en,
    input  logic [TID_W-1:0]  fork_tid,
    input  logic [PTR_W-1:0]  fork_ptr,
    output logic [DATA_W-1:0] print_data,
    output logic              print_valid,
    input  logic              print_ready
`ifdef ALU_GETC_EN
    ,
    input  logic [DATA_W-1:0] getc_data,
    input  logic              getc_valid,
    output logic              getc_ready
`endif
);

    typedef enum logic [3:0] {
        OP_PLUS  = 4'h1,
        OP_MINUS = 4'h2,
        OP_INC   = 4'h3,
        OP_DEC   = 4'h4,
        OP_BRZ   = 4'h5,
        OP_BR    = 4'h6,
        OP_BRNZ  = 4'h7,
        OP_PRINT = 4'h9,
        OP_GETC  = 4'hA
    } op_e;

    localparam logic [PTR_W-1:0]  P_RST = PTR_W'(PTR_RESET);
    localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);
    localparam logic [PTR_W-1:0]  ONE_P = PTR_W'(1);

    logic              r_stage_valid;
    logic [15:0]       r_ins;
    logic [DATA_W-1:0] r_val;
    logic [TID_W-1:0]  r_tid;
    logic [PTR_W-1:0]  r_ptr [NTHREADS];

    op_e               w_op;
    logic              w_stall;
    logic              w_ptr_upd;
    logic              w_br_fire;
    logic [PTR_W-1:0]  w_ptr_cur;
    logic [PTR_W-1:0]  w_ptr_next;

    assign w_op      = op_e'(r_ins[15:12]);
    assign w_ptr_cur = r_ptr[r_tid];
    assign ptr_wb    = w_ptr_cur;
    assign stall     = w_stall;

    always_comb begin
        w_stall     = 1'b0;
        w_ptr_upd   = 1'b0;
        w_br_fire   = 1'b0;
        w_ptr_next  = w_ptr_cur;
        val_out     = '0;
        wb_en       = 1'b0;
        wb_tid      = '0;
        print_data  = '0;
        print_valid = 1'b0;
        branch_val  = '0;
        branch_en   = 1'b0;
        branch_tid  = '0;
`ifdef ALU_GETC_EN
        getc_ready  = 1'b0;
`endif
        if (r_stage_valid) begin
            case (w_op)
                OP_PLUS:  begin val_out = r_val + ONE_D; wb_en = 1'b1; wb_tid = r_tid; end
                OP_MINUS: begin val_out = r_val - ONE_D; wb_en = 1'b1; wb_tid = r_tid; end
                OP_INC:   begin w_ptr_upd = 1'b1; w_ptr_next = w_ptr_cur + ONE_P; end
                OP_DEC:   begin w_ptr_upd = 1'b1; w_ptr_next = w_ptr_cur - ONE_P; end
                OP_BRZ:   w_br_fire = (r_val == '0);
                OP_BR:    w_br_fire = 1'b1;
                OP_BRNZ:  w_br_fire = |r_val;
                OP_PRINT: begin
                    print_valid = 1'b1;
                    print_data  = r_val;
                    w_stall     = ~print_ready;
                end
`ifdef ALU_GETC_EN
                OP_GETC:  begin
                    getc_ready = 1'b1;
                    w_stall    = ~getc_valid;
                    val_out    = getc_data;
                    wb_en      = getc_valid;
                    wb_tid     = r_tid;
                end
`endif
                default: ;
            endcase
        end
        if (w_br_fire) begin
            branch_en  = 1'b1;
            branch_val = {4'b0, r_ins[11:0]};
            branch_tid = r_tid;
        end
        // a same-cycle fork into the staged thread overrides the INC/DEC result
        ptr_select = w_ptr_cur;
        if (w_ptr_upd)
            ptr_select = (fork_en && fork_tid == r_tid) ? fork_ptr : w_ptr_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
            r_ins         <= '0;
            r_val         <= '0;
            r_tid         <= '0;
        end else if (!w_stall) begin
            r_stage_valid <= ins_valid;
            if (ins_valid) begin
                r_ins <= ins_in;
                r_val <= val_in;
                r_tid <= tid_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned t = 0; t < NTHREADS; t++) begin
            if (rst)
                r_ptr[t] <= P_RST;
            else if (fork_en && fork_tid == TID_W'(t))
                r_ptr[t] <= fork_ptr;
            else if (w_ptr_upd && !w_stall && r_tid == TID_W'(t))
                r_ptr[t] <= w_ptr_next;
        end
    end

endmodule

// File: tb/tb_bf_alu_mt.sv
// Directed self-checking bench for bf_alu_mt (default parameters, ALU_GETC_EN optional).
module tb_bf_alu_mt;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ins_in;
    logic        ins_valid;
    logic [1:0]  tid_in;
    logic [15:0] val_in;
    logic        stall;
    logic [15:0] val_out;
    logic        wb_en;
    logic [1:0]  wb_tid;
    logic [15:0] ptr_select;
    logic [15:0] ptr_wb;
    logic [15:0] branch_val;
    logic        branch_en;
    logic [1:0]  branch_tid;
    logic        fork_en;
    logic [1:0]  fork_tid;
    logic [15:0] fork_ptr;
    logic [15:0] print_data;
    logic        print_valid;
    logic        print_ready;
`ifdef ALU_GETC_EN
    logic [15:0] getc_data;
    logic        getc_valid;
    logic        getc_ready;
`endif

    int n_vec = 0;
    int n_err = 0;

    bf_alu_mt #(.DATA_W(16), .PTR_W(16), .NTHREADS(4), .PTR_RESET(128)) dut (
        .clk(clk), .rst(rst), .ins_in(ins_in), .ins_valid(ins_valid), .tid_in(tid_in),
        .val_in(val_in), .stall(stall), .val_out(val_out), .wb_en(wb_en), .wb_tid(wb_tid),
        .ptr_select(ptr_select), .ptr_wb(ptr_wb), .branch_val(branch_val),
        .branch_en(branch_en), .branch_tid(branch_tid), .fork_en(fork_en),
        .fork_tid(fork_tid), .fork_ptr(fork_ptr), .print_data(print_data),
        .print_valid(print_valid), .print_ready(print_ready)
`ifdef ALU_GETC_EN
        , .getc_data(getc_data), .getc_valid(getc_valid), .getc_ready(getc_ready)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input logic [15:0] ins, input logic v, input logic [15:0] val,
                        input logic [1:0] tid);
        ins_in = ins; ins_valid = v; val_in = val; tid_in = tid;
        @(posedge clk); #1;
        ins_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (ptr_wb !== 16'd128) begin n_err++; $display("FAIL reset_ptr_wb got=%h exp=0080", ptr_wb); end
        n_vec++; if (ptr_select !== 16'd128) begin n_err++; $display("FAIL reset_ptr_select got=%h exp=0080", ptr_select); end
        n_vec++; if ({stall, wb_en, branch_en, print_valid} !== 4'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {stall, wb_en, branch_en, print_valid}); end
        n_vec++; if ({val_out, branch_val, print_data} !== 48'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {val_out, branch_val, print_data}); end
    endtask

    task automatic test_pointer();
        step(16'h3000, 1'b1, 16'h0, 2'd0);
        n_vec++; if (ptr_wb !== 16'd128 || ptr_select !== 16'd129) begin n_err++; $display("FAIL inc1 got=%0d/%0d exp=128/129", ptr_wb, ptr_select); end
        step(16'h3000, 1'b1, 16'h0, 2'd0);
        n_vec++; if (ptr_wb !== 16'd129) begin n_err++; $display("FAIL inc2 got=%0d exp=129", ptr_wb); end
        step(16'h4000, 1'b1, 16'h0, 2'd0);
        n_vec++; if (ptr_wb !== 16'd130 || ptr_select !== 16'd129) begin n_err++; $display("FAIL dec got=%0d/%0d exp=130/129", ptr_wb, ptr_select); end
        step(16'h0000, 1'b1, 16'h0, 2'd1);
        n_vec++; if (ptr_wb !== 16'd128 || ptr_select !== 16'd128) begin n_err++; $display("FAIL tid1_ptr got=%0d/%0d exp=128/128", ptr_wb, ptr_select); end
        step(16'h0000, 1'b1, 16'h0, 2'd0);
        n_vec++; if (ptr_wb !== 16'd129) begin n_err++; $display("FAIL tid0_after_dec got=%0d exp=129", ptr_wb); end
    endtask

    task automatic test_arith();
        step(16'h1000, 1'b1, 16'hFFFF, 2'd1);
        n_vec++; if (val_out !== 16'h0000 || wb_en !== 1'b1 || wb_tid !== 2'd1) begin n_err++; $display("FAIL plus_wrap got=%h/%b/%0d exp=0000/1/1", val_out, wb_en, wb_tid); end
        step(16'h2000, 1'b1, 16'h0000, 2'd3);
        n_vec++; if (val_out !== 16'hFFFF || wb_en !== 1'b1 || wb_tid !== 2'd3) begin n_err++; $display("FAIL minus_wrap got=%h/%b/%0d exp=FFFF/1/3", val_out, wb_en, wb_tid); end
        step(16'h1000, 1'b1, 16'h1234, 2'd2);
        n_vec++; if (val_out !== 16'h1235) begin n_err++; $display("FAIL plus got=%h exp=1235", val_out); end
        step(16'h8FFF, 1'b1, 16'h1234, 2'd2);
        n_vec++; if ({wb_en, branch_en, print_valid, stall} !== 4'b0 || val_out !== 16'h0) begin n_err++; $display("FAIL nop got=%b/%h exp=0000/0000", {wb_en, branch_en, print_valid, stall}, val_out); end
`ifndef ALU_GETC_EN
        step(16'hA000, 1'b1, 16'h1234, 2'd2);
        n_vec++; if ({wb_en, stall} !== 2'b0) begin n_err++; $display("FAIL getc_as_nop got=%b exp=00", {wb_en, stall}); end
`endif
        step(16'h0000, 1'b0, 16'h0, 2'd0);
        n_vec++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL idle_wb got=%b exp=0", wb_en); end
    endtask

    task automatic test_branch();
        step(16'h5123, 1'b1, 16'h0000, 2'd2);
        n_vec++; if (branch_en !== 1'b1 || branch_val !== 16'h0123 || branch_tid !== 2'd2) begin n_err++; $display("FAIL brz_taken got=%b/%h/%0d exp=1/0123/2", branch_en, branch_val, branch_tid); end
        step(16'h5123, 1'b1, 16'h0001, 2'd2);
        n_vec++; if (branch_en !== 1'b0 || branch_val !== 16'h0) begin n_err++; $display("FAIL brz_not got=%b/%h exp=0/0000", branch_en, branch_val); end
        step(16'h5123, 1'b1, 16'h8000, 2'd2);
        n_vec++; if (branch_en !== 1'b0) begin n_err++; $display("FAIL brz_msb got=%b exp=0", branch_en); end
        step(16'h7123, 1'b1, 16'h0001, 2'd1);
        n_vec++; if (branch_en !== 1'b1 || branch_val !== 16'h0123 || branch_tid !== 2'd1) begin n_err++; $display("FAIL brnz_taken got=%b/%h/%0d exp=1/0123/1", branch_en, branch_val, branch_tid); end
        step(16'h7123, 1'b1, 16'h0000, 2'd1);
        n_vec++; if (branch_en !== 1'b0) begin n_err++; $display("FAIL brnz_not got=%b exp=0", branch_en); end
        step(16'h6ABC, 1'b1, 16'h0005, 2'd3);
        n_vec++; if (branch_en !== 1'b1 || branch_val !== 16'h0ABC) begin n_err++; $display("FAIL br got=%b/%h exp=1/0ABC", branch_en, branch_val); end
    endtask

    task automatic test_print_stall();
        print_ready = 1'b0;
        step(16'h9000, 1'b1, 16'h0041, 2'd0);
        ins_in = 16'h1000; ins_valid = 1'b1; val_in = 16'h0005; tid_in = 2'd1;
        fork_en = 1'b1; fork_tid = 2'd3; fork_ptr = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (stall !== 1'b1 || print_valid !== 1'b1 || print_data !== 16'h0041 || wb_en !== 1'b0) begin n_err++; $display("FAIL print_hold%0d got=%b/%b/%h/%b exp=1/1/0041/0", i, stall, print_valid, print_data, wb_en); end
            @(posedge clk); #1;
            fork_en = 1'b0;
        end
        print_ready = 1'b1; #1;
        n_vec++; if (stall !== 1'b0 || print_valid !== 1'b1) begin n_err++; $display("FAIL print_retire got=%b/%b exp=0/1", stall, print_valid); end
        @(posedge clk); #1;
        ins_valid = 1'b0;
        n_vec++; if (val_out !== 16'h0006 || wb_en !== 1'b1 || wb_tid !== 2'd1 || print_valid !== 1'b0) begin n_err++; $display("FAIL after_print got=%h/%b/%0d/%b exp=0006/1/1/0", val_out, wb_en, wb_tid, print_valid); end
        step(16'h0000, 1'b1, 16'h0, 2'd3);
        n_vec++; if (ptr_wb !== 16'h0300) begin n_err++; $display("FAIL fork_in_stall got=%h exp=0300", ptr_wb); end
    endtask

    task automatic test_fork();
        do_reset();
        step(16'h3000, 1'b1, 16'h0, 2'd2);
        fork_en = 1'b1; fork_tid = 2'd2; fork_ptr = 16'h0200; #1;
        n_vec++; if (ptr_select !== 16'h0200) begin n_err++; $display("FAIL fork_select got=%h exp=0200", ptr_select); end
        @(posedge clk); #1;
        fork_en = 1'b0;
        step(16'h0000, 1'b1, 16'h0, 2'd2);
        n_vec++; if (ptr_wb !== 16'h0200) begin n_err++; $display("FAIL fork_wins got=%h exp=0200", ptr_wb); end
    endtask

    task automatic test_reset_during_stall();
        print_ready = 1'b0;
        step(16'h9000, 1'b1, 16'h0041, 2'd1);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL pre_reset_stall got=%b exp=1", stall); end
        fork_en = 1'b1; fork_tid = 2'd1; fork_ptr = 16'h0555;
        do_reset();
        fork_en = 1'b0;
        n_vec++; if (stall !== 1'b0 || print_valid !== 1'b0 || ptr_wb !== 16'd128) begin n_err++; $display("FAIL reset_stall got=%b/%b/%h exp=0/0/0080", stall, print_valid, ptr_wb); end
        print_ready = 1'b1;
        step(16'h0000, 1'b1, 16'h0, 2'd1);
        n_vec++; if (ptr_wb !== 16'd128) begin n_err++; $display("FAIL reset_over_fork got=%h exp=0080", ptr_wb); end
    endtask

    initial begin
        rst = 1'b0; ins_in = '0; ins_valid = 1'b0; tid_in = '0; val_in = '0;
        fork_en = 1'b0; fork_tid = '0; fork_ptr = '0; print_ready = 1'b1;
`ifdef ALU_GETC_EN
        getc_data = '0; getc_valid = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_pointer();
        test_arith();
        test_branch();
        test_print_stall();
        test_fork();
        test_reset_during_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bf_alu_mt.md
BF_ALU_MT -- requirements
Module: bf_alu_mt

Interface
REQ-001 Parameter DATA_W, default 16: width of the cell value datapath.
REQ-002 Parameter PTR_W, default 16: width of each thread's data pointer.
REQ-003 Parameter NTHREADS, default 4: number of thread contexts, at least 2; TID_W = clog2(NTHREADS).
REQ-004 Parameter PTR_RESET, default 128: pointer value loaded on reset.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; the ports are clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 ins_in  input  16  instruction; opcode in [15:12], 12-bit branch target in [11:0].
REQ-009 ins_valid  input  1  ins_in, val_in and tid_in are valid this cycle.
REQ-010 tid_in  input  TID_W  thread issuing ins_in.
REQ-011 val_in  input  DATA_W  current cell value for that thread.
REQ-012 stall  output  1  stage is held; the issuer must hold its inputs.
REQ-013 val_out  output  DATA_W  value to write back; wb_en  output  1  write enable; wb_tid  output  TID_W  write-back thread.
REQ-014 ptr_select  output  PTR_W  next pointer of the staged thread; ptr_wb  output  PTR_W  current pointer of the staged thread.
REQ-015 branch_val  output  16  branch target; branch_en  output  1  branch taken; branch_tid  output  TID_W  branching thread.
REQ-016 fork_en  input  1  load a pointer into a thread; fork_tid  input  TID_W  target thread; fork_ptr  input  PTR_W  pointer value to load.
REQ-017 print_data  output  DATA_W; print_valid  output  1; print_ready  input  1.
REQ-018 getc_data  input  DATA_W; getc_valid  input  1; getc_ready  output  1; present only with ALU_GETC_EN.

Function
REQ-019 Opcodes: 1 PLUS, 2 MINUS, 3 INC, 4 DEC, 5 BRZ, 6 BR, 7 BRNZ, 9 PRINT, A GETC; all other opcodes are NOPs.
REQ-020 The stage register SHALL capture ins_in, val_in and tid_in, and set stage-valid, on a clock edge where ins_valid=1 and stall=0.
REQ-021 On an edge with ins_valid=0 and stall=0, stage-valid SHALL clear.
REQ-022 All execute outputs SHALL be combinational from the stage register, giving 1-cycle latency from issue to effect.
REQ-023 When stage-valid=0, or the staged opcode is a NOP, every output SHALL be 0 except ptr_select and ptr_wb.
REQ-024 PLUS and MINUS: val_out = staged val ±1, modulo 2^DATA_W; wb_en=1; wb_tid = staged tid.
REQ-025 INC and DEC: the staged thread's pointer ±1, modulo 2^PTR_W, is written at the edge ending the cycle; ptr_select shows the new value.
REQ-026 BRZ fires when all DATA_W bits of val are 0; BRNZ fires when any bit is set; BR fires always.
REQ-027 On a branch firing: branch_en=1, branch_val = {4'b0, ins[11:0]}, branch_tid = staged tid.
REQ-028 PRINT: print_valid=1 and print_data = val; stall = ~print_ready; the stage is retired on the edge where print_ready=1.
REQ-029 The pointer array SHALL hold NTHREADS independent registers.
REQ-030 ptr_wb SHALL equal ptr[staged tid], and ptr_select SHALL equal ptr[staged tid] unless INC or DEC modifies it.
REQ-031 fork_en loads ptr[fork_tid] = fork_ptr at the next edge, regardless of stall.
REQ-032 If fork_tid equals the staged tid, fork_ptr SHALL win over INC/DEC, and ptr_select SHALL show fork_ptr.
REQ-033 While stall=1, the stage, the pointers (except fork) and all outputs SHALL hold; INC/DEC are applied only on the retiring edge.
REQ-034 With ALU_GETC_EN, GETC sets getc_ready=1, stall = ~getc_valid, val_out = getc_data and wb_en = getc_valid.

Reset
REQ-035 When rst=1 at an edge, every ptr SHALL be set to PTR_RESET[PTR_W-1:0] and stage-valid and the staged instruction SHALL clear.
REQ-036 All outputs SHALL read 0 in the cycle after reset, except ptr_select and ptr_wb, which read PTR_RESET for thread 0.
REQ-037 rst SHALL override fork_en and any pending stall; a held PRINT or GETC is discarded.

Configuration
REQ-038 Macro ALU_GETC_EN defined: the getc_* ports and the GETC opcode are present.
REQ-039 Macro ALU_GETC_EN undefined: the getc_* ports are absent and opcode A is a NOP.

Verification
REQ-040 Reset, then issue tid0 INC, INC, DEC -> ptr_wb for tid0 reads 128, 129, 130; ptr_select after DEC reads 129; tid1 pointer stays 128.
REQ-041 Issue PLUS with val_in=16'hFFFF (DATA_W=16) -> val_out=0, wb_en=1; MINUS with val_in=0 -> val_out=16'hFFFF.
REQ-042 BRZ 0x5123 with val=0 -> branch_en=1, branch_val=0x0123; with val=1 -> branch_en=0; BRNZ 0x7123 with val=1 -> branch_en=1.
REQ-043 PRINT val=0x41 with print_ready low for 3 cycles -> stall=1 and print_valid=1 for those 3 cycles, retired on the 4th; the next instruction executes on the 5th.
REQ-044 fork_en with fork_tid=2 and fork_ptr=0x0200 in the same cycle as a staged tid2 INC -> ptr[2]=0x0200; rst during a held PRINT -> stall=0 next cycle.
